// File: rtl/core_dispatch_queue_pkg.sv
// Purpose: shared decode/dispatch types, idle slot constant and queue pointer type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package core_dispatch_queue_pkg;

    localparam int DQ_DEPTH_DEFAULT = 8;
    localparam int DQ_PTR_W         = $clog2(DQ_DEPTH_DEFAULT);

    // Pointer into a default-sized dispatch queue; wraps naturally.
    typedef logic [DQ_PTR_W-1:0] dq_ptr_t;

    typedef struct packed {
        logic execute;
        logic mem_rd;
        logic mem_wr;
        logic branch;
    } insn_ctrl_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [7:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [15:0] imm;
        insn_ctrl_t  ctrl;
    } insn_decode;

    // Idle slot: all zero, never executes, so dispatch treats it as free to issue.
    localparam insn_decode INSN_IDLE = '0;

endpackage

// File: rtl/core_dispatch_queue_mem.sv
// Purpose: DEPTH-entry decoded-instruction storage, two write and two async read ports.
// Latency: write visible on reads the cycle after the write edge; reads are combinational.
// Backpressure: none; the owner guarantees write addresses never collide.
module core_dispatch_queue_mem
    import core_dispatch_queue_pkg::*;
#(
    parameter int DEPTH = DQ_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     we_a,
    input  logic [$clog2(DEPTH)-1:0] waddr_a,
    input  insn_decode               wdat_a,
    input  logic                     we_b,
    input  logic [$clog2(DEPTH)-1:0] waddr_b,
    input  insn_decode               wdat_b,
    input  logic [$clog2(DEPTH)-1:0] raddr_a,
    input  logic [$clog2(DEPTH)-1:0] raddr_b,
    output insn_decode               rdat_a,
    output insn_decode               rdat_b
);

    insn_decode mem [DEPTH];

    // Storage carries no reset; occupancy tracking decides what is meaningful.
    always_ff @(posedge clk) begin
        if (we_a) mem[waddr_a] <= wdat_a;
        if (we_b) mem[waddr_b] <= wdat_b;
    end

    assign rdat_a = mem[raddr_a];
    assign rdat_b = mem[raddr_b];

endmodule

// File: rtl/core_dispatch_queue.sv
// Purpose: in-order decoded-instruction queue feeding dispatch; 2 in, 0..2 out per cycle, flushable.
// Latency: 1 cycle push-to-present; 0 cycles when built with DISPATCH_QUEUE_BYPASS_EN.
// Backpressure: in_ready drops when fewer than two slots are free (registered count only).
module core_dispatch_queue
    import core_dispatch_queue_pkg::*;
#(
    parameter int DEPTH = DQ_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  insn_decode               in_a,
    input  insn_decode               in_b,
    input  logic                     in_valid_a,
    input  logic                     in_valid_b,
    output logic                     in_ready,
    output insn_decode               cur_a,
    output insn_decode               cur_b,
    input  logic                     dispatch_a,
    input  logic                     dispatch_b,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;
    logic [PTR_W-1:0] head_p1;
    logic [PTR_W-1:0] tail_p1;

    insn_decode rd_a;
    insn_decode rd_b;

    logic push_en;
    logic push_a;
    logic push_b;
    logic pop_a;
    logic pop_b;
    logic vis_a;
    logic vis_b;
    logic skip_a;
    logic skip_b;
    logic we_a;
    logic we_b;

    assign head_p1 = head_q + PTR_W'(1);
    assign tail_p1 = tail_q + PTR_W'(1);

    // Ready only from the registered count so dispatch never reaches decode combinationally.
    assign in_ready = (count_q <= CNT_W'(DEPTH - 2));
    assign count    = count_q;

    core_dispatch_queue_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_a    (we_a),
        .waddr_a (tail_q),
        .wdat_a  (in_a),
        .we_b    (we_b),
        .waddr_b (tail_p1),
        .wdat_b  (in_b),
        .raddr_a (head_q),
        .raddr_b (head_p1),
        .rdat_a  (rd_a),
        .rdat_b  (rd_b)
    );

    // Presentation, push/pop qualification and write-enable suppression for bypassed pops.
    always_comb begin
        push_en = in_ready && !flush && !rst;
        push_a  = push_en && in_valid_a;
        push_b  = push_a && in_valid_b;

        vis_a   = (count_q != '0);
        vis_b   = (count_q >= CNT_W'(2));
        cur_a   = vis_a ? rd_a : INSN_IDLE;
        cur_b   = vis_b ? rd_b : INSN_IDLE;
        skip_a  = 1'b0;
        skip_b  = 1'b0;

`ifdef DISPATCH_QUEUE_BYPASS_EN
        // push_a is already low under flush, so forwarding needs no extra flush term.
        if (count_q == '0) begin
            vis_a = push_a;
            vis_b = push_b;
            cur_a = push_a ? in_a : INSN_IDLE;
            cur_b = push_b ? in_b : INSN_IDLE;
        end else if (count_q == CNT_W'(1)) begin
            vis_b = push_a;
            cur_b = push_a ? in_a : INSN_IDLE;
        end
`endif

        // dispatch_b alone never pops: cur_b cannot leave ahead of cur_a.
        pop_a = dispatch_a && vis_a;
        pop_b = dispatch_a && dispatch_b && vis_b;

`ifdef DISPATCH_QUEUE_BYPASS_EN
        // Entries consumed straight off the input are not stored; head skips their slots.
        if (count_q == '0) begin
            skip_a = pop_a;
            skip_b = pop_b;
        end else if (count_q == CNT_W'(1)) begin
            skip_a = pop_b;
        end
`endif

        we_a = push_a && !skip_a;
        we_b = push_b && !skip_b;
    end

    // Pointer and occupancy update; reset beats flush, flush beats push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + PTR_W'(pop_a) + PTR_W'(pop_b);
            tail_q  <= tail_q + PTR_W'(push_a) + PTR_W'(push_b);
            count_q <= count_q + CNT_W'(push_a) + CNT_W'(push_b)
                               - CNT_W'(pop_a) - CNT_W'(pop_b);
        end
    end

    // A younger instruction without its older partner is a decode protocol error.
    always_ff @(posedge clk) begin
        if (!rst) assert (!(in_valid_b && !in_valid_a));
    end

endmodule

// File: tb/tb_core_dispatch_queue.sv
// Purpose: self-checking bench for core_dispatch_queue using a queue scoreboard.
// Latency: expects one-cycle push-to-present (default build).
// Backpressure: expects in_ready low above DEPTH-2 occupancy, rejected pairs dropped.
module tb_core_dispatch_queue;
    import core_dispatch_queue_pkg::*;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    insn_decode in_a;
    insn_decode in_b;
    logic       in_valid_a;
    logic       in_valid_b;
    logic       in_ready;
    insn_decode cur_a;
    insn_decode cur_b;
    logic       dispatch_a;
    logic       dispatch_b;
    logic [3:0] count;

    insn_decode exp_q [$];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    core_dispatch_queue #(
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_valid_a (in_valid_a),
        .in_valid_b (in_valid_b),
        .in_ready   (in_ready),
        .cur_a      (cur_a),
        .cur_b      (cur_b),
        .dispatch_a (dispatch_a),
        .dispatch_b (dispatch_b),
        .count      (count)
    );

    function automatic insn_decode mk(input int n);
        insn_decode d;
        d              = '0;
        d.pc           = 32'h1000 + 32'(n) * 4;
        d.opcode       = 8'(n);
        d.rd           = 5'(n);
        d.rs1          = 5'(n + 1);
        d.rs2          = 5'(n + 2);
        d.imm          = 16'(n * 3);
        d.ctrl.execute = 1'b1;
        d.ctrl.branch  = n[0];
        return d;
    endfunction

    task automatic chk_insn(input string tag, input insn_decode obs, input insn_decode exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs, check presented state, update scoreboard, advance past the edge.
    task automatic step(input logic va, input logic vb, input insn_decode a, input insn_decode b,
                        input logic da, input logic db, input logic fl);
        int   sz;
        logic acc;
        in_valid_a = va;
        in_valid_b = vb;
        in_a       = a;
        in_b       = b;
        dispatch_a = da;
        dispatch_b = db;
        flush      = fl;
        #1;
        sz = exp_q.size();
        chk_val("count", 32'(count), 32'(sz));
        chk_val("in_ready", 32'(in_ready), 32'(sz <= DEPTH - 2));
        chk_insn("cur_a", cur_a, (sz >= 1) ? exp_q[0] : INSN_IDLE);
        chk_insn("cur_b", cur_b, (sz >= 2) ? exp_q[1] : INSN_IDLE);
        acc = (sz <= DEPTH - 2) && !fl;
        if (da && sz >= 1) void'(exp_q.pop_front());
        if (da && db && sz >= 2) void'(exp_q.pop_front());
        if (acc && va) exp_q.push_back(a);
        if (acc && va && vb) exp_q.push_back(b);
        if (fl) exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic da, input logic db);
        step(1'b0, 1'b0, INSN_IDLE, INSN_IDLE, da, db, 1'b0);
    endtask

    initial begin
        rst        = 1'b1;
        flush      = 1'b0;
        in_a       = '0;
        in_b       = '0;
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        dispatch_a = 1'b0;
        dispatch_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state and idle
        for (int i = 0; i < 5; i++) begin
            chk_val("idle_exec_a", 32'(cur_a.ctrl.execute), 32'd0);
            chk_val("idle_exec_b", 32'(cur_b.ctrl.execute), 32'd0);
            idle(1'b0, 1'b0);
        end

        // Two pairs, then single dispatch
        step(1'b1, 1'b1, mk(0), mk(1), 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, mk(2), mk(3), 1'b0, 1'b0, 1'b0);
        chk_val("count_four", 32'(count), 32'd4);
        idle(1'b1, 1'b0);
        chk_insn("after_single_a", cur_a, mk(1));
        chk_insn("after_single_b", cur_b, mk(2));
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b1);

        // Fill to full, rejected pair, dual dispatch reopens
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, mk(4 + 2 * i), mk(5 + 2 * i), 1'b0, 1'b0, 1'b0);
        chk_val("full_ready", 32'(in_ready), 32'd0);
        step(1'b1, 1'b1, mk(100), mk(101), 1'b0, 1'b0, 1'b0);
        idle(1'b1, 1'b1);
        chk_val("reopen_ready", 32'(in_ready), 32'd1);
        repeat (3) idle(1'b1, 1'b1);

        // Steady push-pair plus dual dispatch across pointer wrap
        for (int i = 0; i < 20; i++)
            step(1'b1, 1'b1, mk(200 + 2 * i), mk(201 + 2 * i), 1'b1, 1'b1, 1'b0);
        chk_val("wrap_count", 32'(count), 32'd2);
        idle(1'b1, 1'b1);

        // Flush at count 5 while pushing and dispatching
        step(1'b1, 1'b1, mk(300), mk(301), 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, mk(302), mk(303), 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, mk(304), INSN_IDLE, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, mk(305), mk(306), 1'b1, 1'b1, 1'b1);
        chk_val("flush_count", 32'(count), 32'd0);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);

        // Single entry: dispatch_b alone pops nothing, dual pops only the one
        step(1'b1, 1'b0, mk(7), INSN_IDLE, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1'b1);
        chk_val("b_only_count", 32'(count), 32'd1);
        idle(1'b1, 1'b1);
        chk_val("single_pop_count", 32'(count), 32'd0);
        idle(1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/core_dispatch_queue.md
Name: core_dispatch_queue

Overview:
- Decoded-instruction buffer directly upstream of dispatch hazard checking.
- Accepts up to two in-order decoded instructions per cycle from decode.
- Presents the two oldest entries as cur_a (older) and cur_b (younger).
- Retires 0, 1 or 2 entries per cycle according to dispatch_a/dispatch_b; flushed on branch redirect.

Parameters:
- DEPTH, 8, number of entries; power of two, >= 4.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous active-high reset
- flush  input  1  discard all entries (branch redirect)
- in_a  input  insn_decode  older incoming decoded instruction
- in_b  input  insn_decode  younger incoming decoded instruction
- in_valid_a  input  1  in_a present
- in_valid_b  input  1  in_b present; legal only with in_valid_a
- in_ready  output  1  queue can accept two instructions this cycle
- cur_a  output  insn_decode  oldest entry, or idle slot
- cur_b  output  insn_decode  second-oldest entry, or idle slot
- dispatch_a  input  1  cur_a issued this cycle
- dispatch_b  input  1  cur_b issued this cycle
- count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Storage: circular buffer of DEPTH entries, head/tail pointers of $clog2(DEPTH) bits with natural wrap, plus occupancy counter 0..DEPTH.
- Reset: head = tail = count = 0; in_ready = 1; cur_a and cur_b are idle slots. An idle slot is all-zero insn_decode with ctrl.execute = 0.
- Presentation:
  - count >= 2: cur_a = mem[head], cur_b = mem[head+1].
  - count == 1: cur_a = mem[head], cur_b = idle slot.
  - count == 0: both are idle slots.
  - Idle slots make downstream treat them as always dispatchable; they are never popped.
- Pop: pop_a = dispatch_a && count >= 1; pop_b = dispatch_a && dispatch_b && count >= 2. dispatch_b without dispatch_a pops nothing. head += pop_a + pop_b.
- Push:
  - Only when in_ready && !flush.
  - push_a = in_valid_a; push_b = in_valid_a && in_valid_b.
  - in_a is written at tail, in_b at tail+1; tail += push_a + push_b.
  - in_valid_b without in_valid_a is ignored (simulation assertion).
- in_ready = (DEPTH - count) >= 2, based on registered count only. Pops in the same cycle do not raise it; this avoids a combinational path from dispatch to decode.
- Simultaneous push and pop in one cycle: count_next = count + pushes - pops. Full and empty boundaries are exact; with count == DEPTH, in_ready = 0.
- Flush, synchronous: head = tail = count = 0 next cycle. Same-cycle pushes and pops are discarded. Outputs are idle slots from the next cycle.
- rst has priority over flush; flush has priority over push and pop.
- Latency without the optional feature: an instruction pushed in cycle N appears on cur_a/cur_b no earlier than cycle N+1.

Optional Feature:
- Macro: DISPATCH_QUEUE_BYPASS_EN.
- Defined:
  - When count == 0 and !flush, valid inputs are forwarded combinationally to cur_a/cur_b in the same cycle. in_a goes to cur_a; in_b goes to cur_b.
  - Bypassed entries that are dispatched that cycle are not written; head and tail advance together.
  - Undispatched ones are written normally.
  - When count == 1, in_a is forwarded to cur_b.
- Undefined: no bypass; minimum latency is one cycle. This is the default.

Decomposition:
- In the shared uarch package:
  - constant for the idle insn_decode value;
  - dispatch queue pointer typedef derived from DEPTH default.
- One natural sub-module, core_dispatch_queue_mem:
  - DEPTH-entry insn_decode storage;
  - two write ports, two asynchronous read ports (head, head+1).

Test Plan:
- Reset, then idle: count = 0, in_ready = 1, cur_a.ctrl.execute = 0 and cur_b.ctrl.execute = 0 for 5 cycles.
- Push pairs I0/I1, I2/I3 with dispatch held low → count = 4; cur_a = I0, cur_b = I1. Then dispatch_a = 1, dispatch_b = 0 → next cur_a = I1, cur_b = I2, count = 3.
- Fill DEPTH = 8 with 4 pairs → count = 8, in_ready = 0. Offered pair ignored. Dual dispatch → count = 6, in_ready = 1 the following cycle.
- Wrap: 20 cycles of push-pair plus dual dispatch, steady state count = 2 → instruction order I0..I39 preserved across pointer wrap.
- Flush with count = 5 while pushing a pair and dispatching → next cycle count = 0, outputs idle, the pushed pair absent.
- count = 1 (I7) with dispatch_b = 1, dispatch_a = 1 → only I7 popped, count = 0. With dispatch_a = 0, dispatch_b = 1 → no pop.
